led_duty_meter: RTL and testbench
=================================

# led_duty_meter

Measures the duty cycle of the three RGB LED drive lines over a fixed window of clock cycles and reports per-channel high-time counts through a valid/ready interface. It is the observing end of the LED drive path: it sits beside the LED driver, or in a bench wrapped around it, and turns the red/green/blue waveforms back into numbers. Benches and self-check logic use those numbers to confirm colour and brightness.

## Interface
- WINDOW, 256, measurement window length in clock cycles; legal range is 2 or more.
- CW, $clog2(WINDOW+1), width of each count output, so that a count of WINDOW is representable.
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- red  input  1  red LED drive line, treated as asynchronous.
- green  input  1  green LED drive line, treated as asynchronous.
- blue  input  1  blue LED drive line, treated as asynchronous.
- duty_r  output  CW  number of high cycles of red in the last reported window.
- duty_g  output  CW  number of high cycles of green in the last reported window.
- duty_b  output  CW  number of high cycles of blue in the last reported window.
- valid  output  1  result registers hold an unconsumed result.
- ready  input  1  consumer accepts the result on a clock edge where valid=1.
- overrun  output  1  sticky flag: a completed window was dropped because the result slot was still full.

## Operation
- Input synchronisation: each LED input passes through a 2-FF synchroniser. Only the synchronised value is counted.
- Window counter: wc runs from 0 to WINDOW-1, then wraps to 0, continuously.
- Per-channel high counter: increments on each cycle where its synchronised input is 1.
- End of window (the edge where wc==WINDOW-1):
  - The final count is the accumulated count plus the current cycle's sample, in the range 0..WINDOW.
  - The slot is free if valid==0, or if valid==1 and ready==1 on this same edge. If the slot is free, the final counts load into duty_*, and valid is 1 after the edge.
  - If the slot is not free, the new result is discarded, overrun is set, and duty_* keep their old value.
  - All high counters restart at 0 for the next window. No cycle is lost between windows.
- Handshake:
  - valid falls after an edge with valid&ready=1, unless a new result loads on that same edge; in that case valid stays 1 and the data updates.
  - ready while valid==0 has no effect.
  - duty_* are stable whenever valid==1 and no transfer occurs.
- overrun clears only on rst.

## Timing
- Reset values: duty_r/g/b=0, valid=0, overrun=0. Synchronisers, wc and the high counters also reset to 0.
- Reset is asynchronous and takes effect immediately. Releasing reset mid-window aborts that window; the partial counts are lost.
- Input-to-count latency: 2 cycles, from the synchroniser. The first window after reset therefore counts 0 for its first 2 cycles.
- First valid: asserted after the WINDOW-th rising edge following reset release. After that, a result is produced every WINDOW cycles.
- Output latency: a result is visible on the cycle after the window's final edge.

## Configuration
- LED_DUTY_EDGES_EN defined:
  - Adds outputs edges_r/g/b, each CW bits wide, counting rising edges of each synchronised input within the window.
  - A rising edge spanning the window boundary counts in the new window.
  - These counts load, hold and reset (to 0) exactly like duty_*, under the same valid/ready/overrun rules.
- LED_DUTY_EDGES_EN undefined: the edge ports and edge logic are absent.

## Structure
- Package led_meter_pkg: the default WINDOW constant, and a packed struct holding one channel's result (duty, plus edges when LED_DUTY_EDGES_EN is defined).
- Sub-module led_chan_meter: synchroniser, high counter and optional edge counter for one channel. It takes the window-end strobe as an input and is instantiated three times.
- The top level owns the window counter, result registers, valid/ready logic and overrun.

## Test plan
- All inputs low, WINDOW=16, ready=1: valid pulses every 16 cycles with duty_r=duty_g=duty_b=0 and overrun=0.
- red=1, green=0, blue toggling every cycle, WINDOW=16, ignore the first window: duty_r=16, duty_g=0, duty_b=8.
- ready=0 across two windows: the first result is held unchanged and overrun=1 after the second window's end. Then raise ready=1: valid drops after one edge and overrun stays 1.
- valid=1 with ready=1 on the window-end edge: valid stays 1, duty_* update to the new window, and overrun stays 0.
- Assert rst at wc=7 with red=1: all outputs are 0 immediately. After release, the first valid arrives after the 16th edge with duty_r=14.
- With LED_DUTY_EDGES_EN, blue as a period-4 square wave, WINDOW=16, steady state: edges_b=4, duty_b=8.

Source files
------------

// File: rtl/led_duty_meter_pkg.sv
// Shared constants and per-channel result type for the LED duty meter.
// LED_DUTY_EDGES_EN adds a rising-edge count to each channel result.
package led_meter_pkg;

    localparam int unsigned WINDOW_DEFAULT = 256;
    localparam int unsigned RES_W          = 32;

    // Counts are carried at full width; the top level keeps the low CW bits.
    typedef struct packed {
        logic [RES_W-1:0] duty;
`ifdef LED_DUTY_EDGES_EN
        logic [RES_W-1:0] edges;
`endif
    } chan_res_t;

endpackage

// File: rtl/led_duty_meter_if.sv
// Result bus of the LED duty meter: per-channel counts, valid/ready and overrun.
// LED_DUTY_EDGES_EN adds the per-channel rising-edge counts.
interface led_duty_meter_if #(
    parameter int unsigned CW = 9
);
    logic [CW-1:0] duty_r;
    logic [CW-1:0] duty_g;
    logic [CW-1:0] duty_b;
`ifdef LED_DUTY_EDGES_EN
    logic [CW-1:0] edges_r;
    logic [CW-1:0] edges_g;
    logic [CW-1:0] edges_b;
`endif
    logic          valid;
    logic          ready;
    logic          overrun;

`ifdef LED_DUTY_EDGES_EN
    modport master (output duty_r, duty_g, duty_b, edges_r, edges_g, edges_b,
                    output valid, overrun, input ready);
    modport slave  (input duty_r, duty_g, duty_b, edges_r, edges_g, edges_b,
                    input valid, overrun, output ready);
`else
    modport master (output duty_r, duty_g, duty_b, output valid, overrun, input ready);
    modport slave  (input duty_r, duty_g, duty_b, input valid, overrun, output ready);
`endif

endinterface

// File: rtl/led_duty_meter_chan.sv
// One LED channel: 2-FF synchroniser, high-time counter and, with
// LED_DUTY_EDGES_EN, a rising-edge counter. res_o is the count including this cycle.
module led_chan_meter
    import led_meter_pkg::*;
#(
    parameter int unsigned CW = 9
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      led_i,
    input  logic      win_end_i,
    output chan_res_t res_o
);

    logic [1:0]    sync_q;
    logic          samp;
    logic [CW-1:0] high_q, high_d, high_fin;

    assign samp = sync_q[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            high_q <= '0;
        end else begin
            sync_q <= {sync_q[0], led_i};
            high_q <= high_d;
        end
    end

    always_comb begin
        high_fin = high_q + CW'(samp);
        high_d   = win_end_i ? '0 : high_fin;
    end

`ifdef LED_DUTY_EDGES_EN
    logic          prev_q;
    logic [CW-1:0] edge_q, edge_d, edge_fin;

    // prev_q is not cleared at window end, so a boundary-spanning rise lands in the new window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= 1'b0;
            edge_q <= '0;
        end else begin
            prev_q <= samp;
            edge_q <= edge_d;
        end
    end

    always_comb begin
        edge_fin = edge_q + CW'(samp & ~prev_q);
        edge_d   = win_end_i ? '0 : edge_fin;
    end
`endif

    always_comb begin
        res_o      = '0;
        res_o.duty = RES_W'(high_fin);
`ifdef LED_DUTY_EDGES_EN
        res_o.edges = RES_W'(edge_fin);
`endif
    end

endmodule

// File: rtl/led_duty_meter.sv
// LED duty-cycle meter: window counter, result registers, valid/ready and sticky overrun.
// LED_DUTY_EDGES_EN adds per-channel rising-edge counts to the result.
module led_duty_meter
    import led_meter_pkg::*;
#(
    parameter int unsigned WINDOW = WINDOW_DEFAULT,
    parameter int unsigned CW     = $clog2(WINDOW + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     red,
    input  logic                     green,
    input  logic                     blue,
    led_duty_meter_if.master         res
);

    localparam int unsigned WCW = $clog2(WINDOW);

    logic [WCW-1:0] wc_q, wc_d;
    logic           win_end;
    chan_res_t      cres [3];
    logic [CW-1:0]  duty_q [3];
    logic [CW-1:0]  duty_d [3];
    logic           valid_q, valid_d;
    logic           overrun_q, overrun_d;
    logic           slot_free;
    logic           unused_res_hi;

    assign win_end = (wc_q == WCW'(WINDOW - 1));
    assign wc_d    = win_end ? '0 : wc_q + WCW'(1);

    led_chan_meter #(.CW(CW)) u_chan_r (.clk(clk), .rst(rst), .led_i(red),   .win_end_i(win_end), .res_o(cres[0]));
    led_chan_meter #(.CW(CW)) u_chan_g (.clk(clk), .rst(rst), .led_i(green), .win_end_i(win_end), .res_o(cres[1]));
    led_chan_meter #(.CW(CW)) u_chan_b (.clk(clk), .rst(rst), .led_i(blue),  .win_end_i(win_end), .res_o(cres[2]));

    assign unused_res_hi = ^{cres[0], cres[1], cres[2]};

    // A transfer on the window-end edge frees the slot for the new result.
    assign slot_free = ~valid_q | res.ready;

    always_comb begin
        duty_d    = duty_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (win_end) begin
            if (slot_free) begin
                for (int unsigned i = 0; i < 3; i++) duty_d[i] = cres[i].duty[CW-1:0];
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && res.ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wc_q      <= '0;
            duty_q    <= '{default: '0};
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            wc_q      <= wc_d;
            duty_q    <= duty_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

`ifdef LED_DUTY_EDGES_EN
    logic [CW-1:0] edges_q [3];
    logic [CW-1:0] edges_d [3];

    always_comb begin
        edges_d = edges_q;
        if (win_end && slot_free) begin
            for (int unsigned i = 0; i < 3; i++) edges_d[i] = cres[i].edges[CW-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) edges_q <= '{default: '0};
        else     edges_q <= edges_d;
    end

    assign res.edges_r = edges_q[0];
    assign res.edges_g = edges_q[1];
    assign res.edges_b = edges_q[2];
`endif

    assign res.duty_r  = duty_q[0];
    assign res.duty_g  = duty_q[1];
    assign res.duty_b  = duty_q[2];
    assign res.valid   = valid_q;
    assign res.overrun = overrun_q;

endmodule

// File: tb/tb_led_duty_meter.sv
// Self-checking bench for led_duty_meter (WINDOW=16): history-based model plus directed literal checks.
module tb_led_duty_meter;

    localparam int unsigned WIN = 16;
    localparam int unsigned CW  = $clog2(WIN + 1);

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic red   = 1'b0;
    logic green = 1'b0;
    logic blue  = 1'b0;

    always #5 clk = ~clk;

    led_duty_meter_if #(.CW(CW)) bus ();

    led_duty_meter #(.WINDOW(WIN), .CW(CW)) dut (
        .clk   (clk),
        .rst   (rst),
        .red   (red),
        .green (green),
        .blue  (blue),
        .res   (bus)
    );

    int vectors = 0;
    int fails   = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: effective sample at edge n is the raw input seen at edge n-2.
    bit [2:0] raw_h [$];
    bit [2:0] eff_h [$];
    int       n;
    int       m_duty  [3];
    int       m_edges [3];
    bit       m_valid, m_ov;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            raw_h.delete();
            eff_h.delete();
            n       = 0;
            m_valid = 0;
            m_ov    = 0;
            for (int c = 0; c < 3; c++) begin
                m_duty[c]  = 0;
                m_edges[c] = 0;
            end
        end else begin
            bit [2:0] eff;
            int       d [3];
            int       e [3];
            n++;
            eff = (raw_h.size() >= 2) ? raw_h[raw_h.size() - 2] : 3'b000;
            raw_h.push_back({red, green, blue});
            eff_h.push_back(eff);
            if (n % WIN == 0) begin
                for (int c = 0; c < 3; c++) begin
                    d[c] = 0;
                    e[c] = 0;
                    for (int k = n - WIN; k < n; k++) begin
                        bit cur, prv;
                        cur = eff_h[k][2-c];
                        prv = (k == 0) ? 1'b0 : eff_h[k-1][2-c];
                        if (cur) d[c]++;
                        if (cur && !prv) e[c]++;
                    end
                end
                if (!m_valid || bus.ready) begin
                    m_duty  = d;
                    m_edges = e;
                    m_valid = 1;
                end else begin
                    m_ov = 1;
                end
            end else if (m_valid && bus.ready) begin
                m_valid = 0;
            end
            #1;
            chk("valid",   bus.valid,   m_valid);
            chk("overrun", bus.overrun, m_ov);
            chk("duty_r",  bus.duty_r,  m_duty[0]);
            chk("duty_g",  bus.duty_g,  m_duty[1]);
            chk("duty_b",  bus.duty_b,  m_duty[2]);
`ifdef LED_DUTY_EDGES_EN
            chk("edges_r", bus.edges_r, m_edges[0]);
            chk("edges_g", bus.edges_g, m_edges[1]);
            chk("edges_b", bus.edges_b, m_edges[2]);
`endif
        end
    end

    bit tog_b = 0;
    bit sq_b  = 0;
    int ph    = 0;

    task automatic tick();
        @(negedge clk);
        if (tog_b) blue = ~blue;
        if (sq_b) begin
            ph++;
            blue = ph[1];
        end
    endtask

    task automatic wait_valid();
        bit seen;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            seen = bus.valid;
        end
        vectors++;
        if (!seen) begin
            fails++;
            $display("FAIL wait_valid: got valid=0 for 40 cycles, expected valid=1");
        end
    endtask

    initial begin
        bus.ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("rst_valid",   bus.valid,   0);
        chk("rst_overrun", bus.overrun, 0);
        chk("rst_duty_r",  bus.duty_r,  0);

        // All low, ready=1: first valid after the 16th edge.
        bus.ready = 1'b1;
        repeat (15) tick();
        chk("t1_valid_early", bus.valid, 0);
        tick();
        chk("t1_valid",  bus.valid,  1);
        chk("t1_duty_r", bus.duty_r, 0);
        repeat (20) tick();

        // red=1, green=0, blue toggling.
        red   = 1'b1;
        tog_b = 1;
        repeat (3) wait_valid();
        chk("t2_duty_r", bus.duty_r, 16);
        chk("t2_duty_g", bus.duty_g, 0);
        chk("t2_duty_b", bus.duty_b, 8);

        // Transfer on the window-end edge while a new result loads.
        tick();
        bus.ready = 1'b0;
        wait_valid();
        green = 1'b1;
        repeat (15) tick();
        bus.ready = 1'b1;
        tick();
        chk("t4_valid",   bus.valid,   1);
        chk("t4_duty_g",  bus.duty_g,  14);
        chk("t4_overrun", bus.overrun, 0);

        // ready=0 across the next window end: result held, overrun set.
        bus.ready = 1'b0;
        repeat (16) tick();
        chk("t3_valid",   bus.valid,   1);
        chk("t3_overrun", bus.overrun, 1);
        chk("t3_duty_g",  bus.duty_g,  14);
        bus.ready = 1'b1;
        tick();
        chk("t3_valid_drop", bus.valid,   0);
        chk("t3_ov_sticky",  bus.overrun, 1);

        // Reset at wc=7 with red high.
        tog_b = 0;
        blue  = 1'b0;
        green = 1'b0;
        repeat (6) tick();
        rst = 1'b1;
        #1;
        chk("r_valid",   bus.valid,   0);
        chk("r_overrun", bus.overrun, 0);
        chk("r_duty_r",  bus.duty_r,  0);
        chk("r_duty_g",  bus.duty_g,  0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (15) tick();
        chk("r_valid_early", bus.valid, 0);
        tick();
        chk("r_valid_first", bus.valid,  1);
        chk("r_duty_r",      bus.duty_r, 14);
        chk("r_duty_g",      bus.duty_g, 0);

        // Period-4 square wave on blue.
        sq_b = 1;
        repeat (3) wait_valid();
        chk("sq_duty_b", bus.duty_b, 8);
`ifdef LED_DUTY_EDGES_EN
        chk("sq_edges_b", bus.edges_b, 4);
`endif
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
